deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
//  10-bit TMDS-style link receiver: the return side of the serializer. Samples one serial
//  bit per clk (LSB of each word first), finds word alignment from TMDS control tokens,
//  and emits aligned 10-bit words with a one-cycle valid strobe and decoded control info.
//  Feeds the TMDS 10b->8b decoder and sync recovery in the video capture/loopback path.
// PARAMETERS
//  LOCK_COUNT  4  consecutive tokens at the same boundary needed to enter LOCKED (>=1)
//  MISS_LIMIT  3  consecutive off-boundary tokens in LOCKED that force re-search (>=1)
// PORTS
//  clk         in   1   bit clock, one serial bit sampled per rising edge
//  rst         in   1   asynchronous reset, active-low; all state is cleared while low
//  serial_in   in   1   serial bitstream, LSB of each word first
//  data_out    out  10  aligned word, data_out[0] = first-received bit
//  data_valid  out  1   one-cycle strobe: data_out/is_ctrl/ctrl updated this cycle
//  is_ctrl     out  1   data_out is one of the four control tokens
//  ctrl        out  2   decoded {C1,C0} when is_ctrl=1, else 2'b00
//  locked      out  1   high while FSM is in LOCKED
// BEHAVIOUR
//  Reset (rst=0): data_out=0, data_valid=0, is_ctrl=0, ctrl=0, locked=0, sh=0, cnt=0,
//   match=0, miss=0, state=SEARCH. Takes effect asynchronously; mid-word content is lost.
//  Shift: every edge sh <= {serial_in, sh[9:1]}; after 10 edges the word sits in sh[9:0].
//  Token compare on sh (C1C0 -> word[9:0]): 00=1101010100, 01=0010101011,
//   10=0101010100, 11=1010101011. tok = sh equals any of the four.
//  Phase counter cnt 0..9, increments every edge, wraps 9->0. bnd = (cnt==9).
//  FSM states:
//   SEARCH: tok -> cnt<=0, match<=1, go VERIFY. With LOCK_COUNT=1, go straight to LOCKED.
//           cnt free-runs; bnd is ignored.
//   VERIFY: on bnd&tok: match++. When match+1==LOCK_COUNT, go LOCKED and clear miss.
//           On bnd&!tok: go SEARCH, match<=0. Off-boundary cycles are ignored.
//   LOCKED: on every bnd register sh into data_out, set is_ctrl=tok and ctrl=decoded code,
//           and pulse data_valid on the next cycle.
//           bnd&tok clears miss. (!bnd)&tok increments miss.
//           When miss reaches MISS_LIMIT: go SEARCH, match<=0, miss<=0.
//           Data words at a boundary never affect miss.
//  Simultaneous events: the LOCKED->SEARCH exit, when taken on a cycle, ignores tok that cycle.
//   No realignment occurs in the same cycle.
//  Latency: the edge that samples a word's last bit makes bnd true. data_out and data_valid
//   update on the following edge (1 clk). Steady state in LOCKED: data_valid high 1 of 10 cycles.
//  data_out/is_ctrl/ctrl hold their value between strobes, and also after lock loss.
//   data_valid never asserts outside LOCKED.
//  locked is registered. It is high from the cycle after the LOCKED transition edge until
//   the exit edge.
//  Counters saturate-free: match width clog2(LOCK_COUNT+1), miss width clog2(MISS_LIMIT+1).
// TESTING
//  1 Reset with rst=0 mid-stream, serial_in random
//    -> all outputs 0 within the same cycle; locked=0 after release.
//  2 3 junk bits, then 4x token 00 (1101010100, LSB first)
//    -> locked rises 1 clk after the 4th token completes.
//    Then 10'h155 follows -> data_valid pulse with data_out=10'h155, is_ctrl=0.
//  3 Locked, then token 11 -> data_out=1010101011, is_ctrl=1, ctrl=2'b11.
//    Strobes are exactly 10 clk apart.
//  4 SEARCH, 2 tokens, then data word 10'h0F0 at the boundary
//    -> back to SEARCH, no data_valid, locked=0.
//  5 Locked, then stream slipped by 1 bit, token 01 repeated
//    -> locked drops after the 3rd misaligned token.
//    Relock after 4 more; data_out realigns to 0010101011.
//  6 LOCK_COUNT=1, MISS_LIMIT=1 build: single token locks; single off-phase token unlocks.

Source files
------------

// File: rtl/deserializer.sv
// 10-bit TMDS-style serial receiver: finds word alignment from control tokens and
// presents aligned words with a one-cycle strobe and decoded control information.
module deserializer #(
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [9:0] data_out,
   output logic       data_valid,
   output logic       is_ctrl,
   output logic [1:0] ctrl,
   output logic       locked
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int XW = $clog2(MISS_LIMIT + 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Returns {hit, C1, C0}; C1C0 is 2'b00 when the word is not a control token.
   function automatic logic [2:0] tok_decode(input logic [9:0] w);
      logic [2:0] r;
      case (w)
         10'b1101010100: r = 3'b100;
         10'b0010101011: r = 3'b101;
         10'b0101010100: r = 3'b110;
         10'b1010101011: r = 3'b111;
         default:        r = 3'b000;
      endcase
      return r;
   endfunction

   state_t        state_q;
   logic [9:0]    sh_q;
   logic [9:0]    sh_d;
   logic [3:0]    cnt_q;
   logic [3:0]    cnt_d;
   logic [MW-1:0] match_q;
   logic [XW-1:0] miss_q;
   logic [9:0]    data_q;
   logic          valid_q;
   logic          is_ctrl_q;
   logic [1:0]    ctrl_q;
   logic          locked_q;
   logic          bnd_s;
   logic          tok_s;
   logic [1:0]    code_s;

   // Shift register and phase counter next-state, plus token decode of the current window.
   always_comb begin
      sh_d = {serial_in, sh_q[9:1]};
      bnd_s = (cnt_q == 4'd9);
      if (bnd_s) begin
         cnt_d = 4'd0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
      {tok_s, code_s} = tok_decode(sh_q);
   end

   // Alignment FSM with registered word/strobe/lock outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= SEARCH;
         sh_q      <= 10'd0;
         cnt_q     <= 4'd0;
         match_q   <= '0;
         miss_q    <= '0;
         data_q    <= 10'd0;
         valid_q   <= 1'b0;
         is_ctrl_q <= 1'b0;
         ctrl_q    <= 2'b00;
         locked_q  <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         valid_q <= 1'b0;
         case (state_q)
            SEARCH: begin
               // A token anywhere sets the word phase so the next boundary follows it.
               if (tok_s) begin
                  cnt_q   <= 4'd0;
                  match_q <= MW'(1'b1);
                  if (LOCK_COUNT == 1) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     miss_q   <= '0;
                  end else begin
                     state_q <= VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (bnd_s) begin
                  if (tok_s) begin
                     match_q <= match_q + MW'(1'b1);
                     if (int'(match_q) + 32'sd1 == LOCK_COUNT) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        miss_q   <= '0;
                     end
                  end else begin
                     state_q <= SEARCH;
                     match_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (bnd_s) begin
                  data_q    <= sh_q;
                  is_ctrl_q <= tok_s;
                  ctrl_q    <= code_s;
                  valid_q   <= 1'b1;
                  if (tok_s) begin
                     miss_q <= '0;
                  end
               end else if (tok_s) begin
                  // Off-phase token: the exit consumes it without realigning this cycle.
                  if (int'(miss_q) + 32'sd1 == MISS_LIMIT) begin
                     state_q  <= SEARCH;
                     locked_q <= 1'b0;
                     match_q  <= '0;
                     miss_q   <= '0;
                  end else begin
                     miss_q <= miss_q + XW'(1'b1);
                  end
               end
            end
            default: begin
               state_q  <= SEARCH;
               locked_q <= 1'b0;
               match_q  <= '0;
               miss_q   <= '0;
            end
         endcase
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign is_ctrl    = is_ctrl_q;
   assign ctrl       = ctrl_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: default build plus a LOCK_COUNT=1/MISS_LIMIT=1 build.
module tb_deserializer;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;

   typedef struct packed {
      logic [9:0] data;
      logic       is_ctrl;
      logic [1:0] code;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst1;
   logic       rst2;
   logic       serial_in;
   logic [9:0] d1, d2;
   logic       v1, v2, c1, c2, l1, l2;
   logic [1:0] k1, k2;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_p = 0;
   int   rise1 = -1, fall1 = -1, rise2 = -1, fall2 = -1;
   logic pl1 = 1'b0, pl2 = 1'b0;

   always #5 clk = ~clk;

   deserializer dut1 (
      .clk(clk), .rst(rst1), .serial_in(serial_in), .data_out(d1), .data_valid(v1),
      .is_ctrl(c1), .ctrl(k1), .locked(l1)
   );

   deserializer #(.LOCK_COUNT(1), .MISS_LIMIT(1)) dut2 (
      .clk(clk), .rst(rst2), .serial_in(serial_in), .data_out(d2), .data_valid(v2),
      .is_ctrl(c2), .ctrl(k2), .locked(l2)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one bit; last_p is the rising edge that will sample it.
   task automatic send_bit(input logic b);
      @(negedge clk);
      serial_in = b;
      last_p = cyc + 1;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic push1(input logic [9:0] d, input logic c, input logic [1:0] k, input int cy);
      exp_t e;
      e.data = d; e.is_ctrl = c; e.code = k; e.cyc = cy;
      q1.push_back(e);
   endtask

   task automatic push2(input logic [9:0] d, input logic c, input logic [1:0] k, input int cy);
      exp_t e;
      e.data = d; e.is_ctrl = c; e.code = k; e.cyc = cy;
      q2.push_back(e);
   endtask

   // Monitor: pop and compare on every strobe, and record lock rise/fall cycles.
   always @(negedge clk) begin
      if (v1) begin
         if (q1.size() == 0) begin
            check("dut1_extra_strobe", 1, 0);
         end else begin
            e1 = q1.pop_front();
            check("dut1_word", int'({c1, k1, d1}), int'({e1.is_ctrl, e1.code, e1.data}));
            check("dut1_strobe_cycle", cyc, e1.cyc);
         end
      end
      if (v2) begin
         if (q2.size() == 0) begin
            check("dut2_extra_strobe", 1, 0);
         end else begin
            e2 = q2.pop_front();
            check("dut2_word", int'({c2, k2, d2}), int'({e2.is_ctrl, e2.code, e2.data}));
            check("dut2_strobe_cycle", cyc, e2.cyc);
         end
      end
      if (l1 && !pl1) rise1 = cyc;
      if (!l1 && pl1) fall1 = cyc;
      if (l2 && !pl2) rise2 = cyc;
      if (!l2 && pl2) fall2 = cyc;
      pl1 = l1;
      pl2 = l2;
   end

   initial begin
      int p4;
      int exp_rise;
      int exp_fall;
      rst1 = 1'b0;
      rst2 = 1'b0;
      serial_in = 1'b0;

      // Reset held with a random stream: everything stays cleared.
      for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(1, 0)));
      check("reset_dut1", int'({d1, v1, c1, k1, l1}), 0);
      check("reset_dut2", int'({d2, v2, c2, k2, l2}), 0);
      send_bit(1'b0);
      rst1 = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      check("locked_after_release", int'(l1), 0);

      // Junk bits, four T00 tokens, then a data word.
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      for (int i = 0; i < 4; i++) send_word(T00);
      p4 = last_p;
      send_word(10'h155);
      push1(10'h155, 1'b0, 2'b00, last_p + 1);
      check("lock_rise_4th_token", rise1, p4 + 1);

      // Each control token decodes; strobes land 10 cycles apart.
      send_word(T11); push1(T11, 1'b1, 2'b11, last_p + 1);
      send_word(T10); push1(T10, 1'b1, 2'b10, last_p + 1);
      send_word(T01); push1(T01, 1'b1, 2'b01, last_p + 1);
      send_word(T00); push1(T00, 1'b1, 2'b00, last_p + 1);
      for (int i = 0; i < 3; i++) send_bit(1'b0);

      // Asynchronous reset between edges clears outputs immediately.
      #2 rst1 = 1'b0;
      #1 check("async_reset_outputs", int'({d1, v1, c1, k1, l1}), 0);
      send_bit(1'b0);
      send_bit(1'b0);
      rst1 = 1'b1;

      // Two tokens then a data word at the boundary fall back to SEARCH.
      send_word(T00);
      send_word(T00);
      send_word(10'h0F0);
      check("locked_after_bad_verify", int'(l1), 0);
      for (int i = 0; i < 4; i++) send_word(T00);
      p4 = last_p;
      send_word(T01); push1(T01, 1'b1, 2'b01, last_p + 1);
      check("relock_needs_four_fresh", rise1, p4 + 1);

      // One-bit slip: three off-phase tokens drop lock, four more relock.
      send_bit(1'b0);
      exp_fall = 0;
      exp_rise = 0;
      for (int i = 1; i <= 8; i++) begin
         send_word(T01);
         if (i <= 3) push1(10'h156, 1'b0, 2'b00, last_p);
         if (i == 3) exp_fall = last_p + 1;
         if (i == 7) exp_rise = last_p + 1;
         if (i == 8) push1(T01, 1'b1, 2'b01, last_p + 1);
      end
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      check("slip_lock_fall", fall1, exp_fall);
      check("slip_relock_rise", rise1, exp_rise);
      rst1 = 1'b0;

      // Minimal build: one token locks, one off-phase token unlocks.
      send_bit(1'b0);
      rst2 = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      send_word(T00);
      exp_rise = last_p + 1;
      send_word(T10); push2(T10, 1'b1, 2'b10, last_p + 1);
      check("min_lock_rise", rise2, exp_rise);
      send_bit(1'b0);
      send_word(T00);
      push2(10'h2A8, 1'b0, 2'b00, last_p);
      exp_fall = last_p + 1;
      for (int i = 0; i < 12; i++) send_bit(1'b0);
      check("min_lock_fall", fall2, exp_fall);
      check("min_locked_low", int'(l2), 0);

      check("dut1_queue_drained", q1.size(), 0);
      check("dut2_queue_drained", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
